// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int PW    = ADDR_W + 1;

  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo_param: illegal AE_LEVEL/AF_LEVEL for DEPTH");
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     cnt;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Occupancy comes straight from the registered pointers; the wrap bit
  // makes full and empty distinguishable.
  assign cnt          = wr_ptr_q - rd_ptr_q;
  assign count        = cnt;
  assign full         = (cnt == PW'(DEPTH));
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= PW'(AF_LEVEL));
  assign almost_empty = (cnt <= PW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    // A fresh error event in the same cycle beats clr_err.
    ovf_d = (wr_en & full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d = (rd_en & empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? mem_q[rd_ptr_q[ADDR_W-1:0]] : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed table, corner sequences and random
// traffic, all checked against a queue-based occupancy/data model.
module tb_sync_fifo_param;
  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [6:0] count;
  logic       overflow, underflow;

  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents as a queue, plus the sticky flags and the
  // registered read port.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_rv = 1'b0;
  logic [7:0] m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r,
                            input logic c, input logic n);
    int sz;
    sz = q.size();
    if (!n) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_ovf = (w && sz == DEPTH) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && sz == 0)     ? 1'b1 : (c ? 1'b0 : m_unf);
      m_rv  = 1'b0;
      if (r && sz != 0) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (w && sz != DEPTH) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    vectors++;
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 60));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
    if (sz != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`else
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
`endif
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic n);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = n;
    @(posedge clk);
    model_edge(w, d, r, c, n);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       n;
    int         cnt;
    logic       emp;
    logic       unf;
    logic       rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Hand-computed expectations for the registered-read port.
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h33};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h33};
    tbl[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 8'h44};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h44};

`ifndef FIFO_FWFT_EN
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].n);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].unf));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
    end
`endif

    // Fill to full, overflow, drain in order.
    step(0, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    for (int i = 1; i <= 64; i++) begin
      step(1, 8'(i), 0, 0, 1);
      chk("af_threshold", 32'(almost_full), 32'(i >= 60));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 64);
    step(1, 8'h41, 0, 0, 1);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 64);
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 1, 0, 1);
`ifndef FIFO_FWFT_EN
      chk("drain_rd_data", 32'(rd_data), 32'(i));
      chk("drain_rd_valid", 32'(rd_valid), 1);
`endif
    end
    chk("drain_empty", 32'(empty), 1);

    // Underflow and clear priority.
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1);
    chk("unf_set", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
`ifndef FIFO_FWFT_EN
    chk("unf_rd_valid", 32'(rd_valid), 0);
`endif
    step(0, 0, 0, 1, 1);
    chk("unf_clr", 32'(underflow), 0);
    step(0, 0, 1, 1, 1);
    chk("unf_set_beats_clr", 32'(underflow), 1);

    // Full with simultaneous write and read.
    for (int i = 0; i < 64; i++) step(1, 8'(8'hC0 + i), 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 1, 0, 1);
    chk("full_rw_ovf", 32'(overflow), 1);

    // Streaming through pointer wrap at constant occupancy.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 0, 0, 1);
    for (int i = 0; i < 200; i++) step(1, 8'($urandom), 1, 0, 1);
    chk("stream_count", 32'(count), 3);

    // Mid-stream reset discards contents.
    for (int i = 0; i < 17; i++) step(1, 8'(8'h50 + i), 0, 0, 1);
    chk("pre_rst_count", 32'(count), 20);
    step(1, 8'hEE, 1, 1, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_full", 32'(full), 0);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
`ifndef FIFO_FWFT_EN
    chk("midrst_rd_data", 32'(rd_data), 0);
`endif
    step(1, 8'h77, 0, 0, 1);
    step(0, 0, 1, 0, 1);
`ifndef FIFO_FWFT_EN
    chk("post_rst_data", 32'(rd_data), 32'h77);
`endif

`ifdef FIFO_FWFT_EN
    step(0, 0, 0, 0, 0);
    step(1, 8'hA5, 0, 0, 1);
    chk("fwft_valid", 32'(rd_valid), 1);
    chk("fwft_data", 32'(rd_data), 32'hA5);
    step(0, 0, 1, 0, 1);
    chk("fwft_pop_empty", 32'(empty), 1);
`endif

    // Random traffic with alternating write/read bias to reach both ends.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int wb;
      wb = ((i / 300) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wb, 8'($urandom),
           $urandom_range(0, 99) < (100 - wb),
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 999) >= 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
